rv_multicycle_ctrl: RTL and testbench

- Parametrised multicycle control unit for the RISC-V computer; next generation of the single-path R/I-type sequencer.
- Owns the PC, the fetch handshake, the instruction register, the immediate generator and every datapath control strobe.
- Adds the following over the previous sequencer:
  - LOAD/STORE with a data-memory req/ack handshake.
  - BEQ/BNE branches.
  - LUI.
  - Sign-extended immediates.
  - A trap state for illegal opcodes.
- Sits between instruction memory, data memory and the datapath (register bank + ALU).

---
 rtl/rv_multicycle_ctrl.sv | 263 ++++++++++++++++++++++++++
 tb/tb_rv_multicycle_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multicycle control unit for the RISC-V computer.
// Owns the PC, instruction fetch handshake, instruction register, immediate
// generation and all datapath control strobes. Supports OP, OP-IMM, LOAD,
// STORE, BEQ/BNE and LUI; other opcodes trap or act as NOPs.
//
// Parameters:
//   XLEN            datapath / PC width (only 32 is legal)
//   PC_RESET        PC value loaded on reset
//   TRAP_ON_ILLEGAL 1: unknown opcode enters TRAP, 0: treated as NOP
//
// Ports:
//   clk, rst_n                   clock, synchronous active-low reset
//   imem_req/addr/ack/rdata      instruction fetch handshake
//   dmem_req/we/ack              data memory handshake (we = store)
//   alu_zero                     ALU result == 0 from datapath
//   rs1, rs2, rd                 register addresses from IR
//   alu_op, alu_src_imm,
//   alu_a_zero, imm              ALU control and sign-extended immediate
//   rf_we, wb_sel                register write strobe, writeback select
//   pc, halted                   current PC, TRAP indication
//
// Optional feature macro RV_PERF_COUNTERS_EN adds 64-bit cycle_cnt and
// instret_cnt outputs.
module rv_multicycle_ctrl #(
    parameter int unsigned      XLEN            = 32,
    parameter logic [XLEN-1:0]  PC_RESET        = '0,
    parameter bit               TRAP_ON_ILLEGAL = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            dmem_req,
    output logic            dmem_we,
    input  logic            dmem_ack,
    input  logic            alu_zero,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [3:0]      alu_op,
    output logic            alu_src_imm,
    output logic            alu_a_zero,
    output logic [XLEN-1:0] imm,
    output logic            rf_we,
    output logic            wb_sel,
    output logic [XLEN-1:0] pc
`ifdef RV_PERF_COUNTERS_EN
    ,
    output logic [63:0]     cycle_cnt,
    output logic [63:0]     instret_cnt
`endif
    ,
    output logic            halted
);

    if (XLEN != 32) begin : g_xlen_check
        $error("rv_multicycle_ctrl: XLEN must be 32");
    end

    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_LUI    = 7'b0110111;
    localparam logic [31:0] IR_NOP     = 32'h0000_0013;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXECUTE,
        S_MEM,
        S_WRITEBACK,
        S_TRAP
    } state_t;

    state_t          state, state_nxt;
    logic [XLEN-1:0] pc_nxt;
    logic [31:0]     ir, ir_nxt;

    // IR field decode
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_op, is_opimm, is_load, is_store, is_branch, is_lui;
    logic       supported;
    logic       taken;

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign rs1       = ir[19:15];
    assign rs2       = ir[24:20];
    assign rd        = ir[11:7];
    assign is_op     = (opcode == OPC_OP);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    // only BEQ (000) and BNE (001) are implemented
    assign is_branch = (opcode == OPC_BRANCH) && (funct3[2:1] == 2'b00);
    assign is_lui    = (opcode == OPC_LUI);
    assign supported = is_op | is_opimm | is_load | is_store | is_branch | is_lui;
    // BEQ takes on zero, BNE on non-zero
    assign taken     = alu_zero ^ funct3[0];

    // Immediate formats, all sign-extended
    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_u;
    assign imm_i = XLEN'($signed(ir[31:20]));
    assign imm_s = XLEN'($signed({ir[31:25], ir[11:7]}));
    assign imm_b = XLEN'($signed({ir[31], ir[7], ir[30:25], ir[11:8], 1'b0}));
    assign imm_u = XLEN'($signed({ir[31:12], 12'h000}));

    logic [XLEN-1:0] pc_plus4, pc_target;
    assign pc_plus4  = pc + XLEN'(4);
    assign pc_target = pc + imm;
    assign imem_addr = pc;

    // State, PC and IR registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_FETCH;
            pc    <= PC_RESET;
            ir    <= IR_NOP;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            ir    <= ir_nxt;
        end
    end

    // Next-state, PC and IR update
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        ir_nxt    = ir;
        case (state)
            S_FETCH: begin
                if (imem_ack) begin
                    ir_nxt    = imem_rdata;
                    state_nxt = S_DECODE;
                end
            end
            S_DECODE: begin
                if (supported) begin
                    state_nxt = S_EXECUTE;
                end else if (TRAP_ON_ILLEGAL) begin
                    state_nxt = S_TRAP;
                end else begin
                    pc_nxt    = pc_plus4;
                    state_nxt = S_FETCH;
                end
            end
            S_EXECUTE: begin
                if (is_branch) begin
                    pc_nxt    = taken ? pc_target : pc_plus4;
                    state_nxt = S_FETCH;
                end else if (is_load || is_store) begin
                    state_nxt = S_MEM;
                end else begin
                    state_nxt = S_WRITEBACK;
                end
            end
            S_MEM: begin
                if (dmem_ack) begin
                    if (is_store) begin
                        pc_nxt    = pc_plus4;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_WRITEBACK;
                    end
                end
            end
            S_WRITEBACK: begin
                pc_nxt    = pc_plus4;
                state_nxt = S_FETCH;
            end
            S_TRAP: begin
                state_nxt = S_TRAP;
            end
            default: begin
                state_nxt = S_FETCH;
            end
        endcase
    end

    // Handshake and write strobes (Moore). FETCH is the reset state, so the
    // fetch request is masked while rst_n is low to keep it quiet in reset.
    always_comb begin
        imem_req = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        rf_we    = 1'b0;
        halted   = 1'b0;
        case (state)
            S_FETCH:     imem_req = rst_n;
            S_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = is_store;
            end
            S_WRITEBACK: rf_we  = (rd != 5'd0);
            S_TRAP:      halted = 1'b1;
            default: ;
        endcase
    end

    // ALU control and immediate select, decoded from IR
    always_comb begin
        alu_op      = {1'b0, funct3};
        alu_src_imm = 1'b1;
        alu_a_zero  = 1'b0;
        imm         = imm_i;
        wb_sel      = is_load;
        case (opcode)
            OPC_OP: begin
                alu_op      = {ir[30], funct3};
                alu_src_imm = 1'b0;
            end
            OPC_OPIMM: begin
                // funct7[5] only selects SRAI vs SRLI
                alu_op = {(funct3 == 3'b101) ? ir[30] : 1'b0, funct3};
            end
            OPC_LOAD: begin
                alu_op = 4'b0000;
            end
            OPC_STORE: begin
                alu_op = 4'b0000;
                imm    = imm_s;
            end
            OPC_BRANCH: begin
                alu_op      = 4'b1000;
                alu_src_imm = 1'b0;
                imm         = imm_b;
            end
            OPC_LUI: begin
                alu_op     = 4'b0000;
                alu_a_zero = 1'b1;
                imm        = imm_u;
            end
            default: ;
        endcase
    end

`ifdef RV_PERF_COUNTERS_EN
    // An instruction retires on any entry into FETCH from another state
    logic retire_c;
    assign retire_c = (state_nxt == S_FETCH) && (state != S_FETCH);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cycle_cnt   <= 64'd0;
            instret_cnt <= 64'd0;
        end else begin
            if (state != S_TRAP) begin
                cycle_cnt <= cycle_cnt + 64'd1;
            end
            if (retire_c) begin
                instret_cnt <= instret_cnt + 64'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// Testbench for rv_multicycle_ctrl: randomized instruction stream with a
// per-instruction reference model, scoreboard queue and decoupled monitor,
// plus directed reset/trap/wrap scenarios.
module tb_rv_multicycle_ctrl;

    localparam int unsigned XLEN            = 32;
    localparam logic [31:0] PC_RESET        = 32'h0000_0000;
    localparam bit          TRAP_ON_ILLEGAL = 1'b1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_ack;
    logic [31:0] imem_addr, imem_rdata;
    logic        dmem_req, dmem_we, dmem_ack, alu_zero;
    logic [4:0]  rs1, rs2, rd;
    logic [3:0]  alu_op;
    logic        alu_src_imm, alu_a_zero, rf_we, wb_sel, halted;
    logic [31:0] imm, pc;
`ifdef RV_PERF_COUNTERS_EN
    logic [63:0] cycle_cnt, instret_cnt;
`endif

    rv_multicycle_ctrl #(
        .XLEN(XLEN), .PC_RESET(PC_RESET), .TRAP_ON_ILLEGAL(TRAP_ON_ILLEGAL)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_zero(alu_zero),
        .rs1(rs1), .rs2(rs2), .rd(rd),
        .alu_op(alu_op), .alu_src_imm(alu_src_imm), .alu_a_zero(alu_a_zero),
        .imm(imm), .rf_we(rf_we), .wb_sel(wb_sel), .pc(pc)
`ifdef RV_PERF_COUNTERS_EN
        , .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
`endif
        , .halted(halted)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic        az;
        int          iwait;
        int          dwait;
    } stim_t;

    typedef struct {
        logic [31:0] pc, ins, imm, npc;
        logic        trap, chk_dec, chk_imm, src_imm, a_zero, wb_sel, dwe;
        logic [3:0]  alu_op;
        logic [4:0]  rd;
        int          nwe, ndm, lat;
    } exp_t;

    stim_t       issue_q[$];
    exp_t        exp_q[$];
    int          errors = 0;
    int          nchecks = 0;
    int          rand_left = 0;
    bit          sb_hold = 1'b1;
    bit          mon_active = 1'b0;
    bit          mon_done = 1'b1;
    bit          cur_loaded = 1'b0;
    logic [31:0] model_pc = PC_RESET;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] expv);
        nchecks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endfunction

    function automatic void fail(string name);
        nchecks++;
        errors++;
        $display("FAIL %s (t=%0t)", name, $time);
    endfunction

    // Instruction-level reference: what one instruction must do, and where the PC goes next
    function automatic exp_t model(logic [31:0] ins, logic [31:0] cpc, logic az, int dw);
        exp_t e;
        logic [2:0]  f3;
        logic [31:0] ii, is, ib, iu;
        f3 = ins[14:12];
        ii = 32'($signed(ins[31:20]));
        is = 32'($signed({ins[31:25], ins[11:7]}));
        ib = 32'($signed({ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}));
        iu = {ins[31:12], 12'h000};
        e.pc = cpc; e.ins = ins; e.trap = 1'b0; e.chk_dec = 1'b1; e.chk_imm = 1'b1;
        e.imm = ii; e.src_imm = 1'b1; e.a_zero = 1'b0; e.wb_sel = 1'b0; e.dwe = 1'b0;
        e.alu_op = 4'h0; e.rd = ins[11:7]; e.nwe = 0; e.ndm = 0; e.lat = 4;
        e.npc = cpc + 32'd4;
        case (ins[6:0])
            7'b0110011: begin
                e.alu_op = {ins[30], f3}; e.src_imm = 1'b0; e.chk_imm = 1'b0;
                e.nwe = (e.rd != 0) ? 1 : 0;
            end
            7'b0010011: begin
                e.alu_op = {(f3 == 3'd5) ? ins[30] : 1'b0, f3};
                e.nwe = (e.rd != 0) ? 1 : 0;
            end
            7'b0110111: begin
                e.imm = iu; e.a_zero = 1'b1; e.nwe = (e.rd != 0) ? 1 : 0;
            end
            7'b0000011: begin
                e.wb_sel = 1'b1; e.nwe = (e.rd != 0) ? 1 : 0;
                e.ndm = dw + 1; e.lat = 5 + dw;
            end
            7'b0100011: begin
                e.imm = is; e.dwe = 1'b1; e.ndm = dw + 1; e.lat = 4 + dw;
            end
            default: begin
                if (ins[6:0] == 7'b1100011 && f3 <= 3'd1) begin
                    e.alu_op = 4'b1000; e.src_imm = 1'b0; e.imm = ib; e.lat = 3;
                    if (az ^ f3[0]) e.npc = cpc + ib;
                end else begin
                    e.chk_dec = 1'b0; e.lat = 2;
                    if (TRAP_ON_ILLEGAL) begin
                        e.trap = 1'b1; e.npc = cpc;
                    end
                end
            end
        endcase
        return e;
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        logic [31:0] r;
        r = $urandom();
        case ($urandom_range(0, 5))
            0: r[6:0] = 7'b0110011;
            1: r[6:0] = 7'b0010011;
            2: r[6:0] = 7'b0000011;
            3: r[6:0] = 7'b0100011;
            4: begin r[6:0] = 7'b1100011; r[14:13] = 2'b00; end
            default: r[6:0] = 7'b0110111;
        endcase
        if ($urandom_range(0, 7) == 0) r[11:7] = 5'd0;
        s.ins = r;
        s.az = 1'($urandom_range(0, 1));
        s.iwait = $urandom_range(0, 2);
        s.dwait = $urandom_range(0, 3);
        return s;
    endfunction

    function automatic void push_ins(logic [31:0] ins, logic az, int iw, int dw);
        stim_t s;
        s.ins = ins; s.az = az; s.iwait = iw; s.dwait = dw;
        issue_q.push_back(s);
    endfunction

    // Memory responder: drives acks shortly after each posedge, issues stimulus
    stim_t cur;
    exp_t  issued;
    int    icnt = 0, dcnt = 0, dwait_cur = 0;
    initial begin
        imem_ack = 1'b0; imem_rdata = 32'h0; dmem_ack = 1'b0; alu_zero = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (sb_hold) begin
                imem_ack = 1'b0; dmem_ack = 1'b0; cur_loaded = 1'b0; dcnt = 0;
            end else begin
                imem_ack = 1'b0;
                if (imem_req) begin
                    if (!cur_loaded && (issue_q.size() > 0 || rand_left > 0)) begin
                        if (issue_q.size() > 0) cur = issue_q.pop_front();
                        else begin cur = rand_stim(); rand_left--; end
                        cur_loaded = 1'b1;
                        icnt = cur.iwait;
                    end
                    if (cur_loaded) begin
                        if (icnt == 0) begin
                            issued = model(cur.ins, model_pc, cur.az, cur.dwait);
                            exp_q.push_back(issued);
                            model_pc = issued.npc;
                            imem_ack = 1'b1; imem_rdata = cur.ins; alu_zero = cur.az;
                            dwait_cur = cur.dwait; cur_loaded = 1'b0;
                        end else begin
                            icnt--;
                        end
                    end
                end else begin
                    imem_ack = ($urandom_range(0, 3) == 0);
                    imem_rdata = $urandom();
                end
                if (dmem_req) begin
                    if (dcnt == 0) dmem_ack = 1'b1;
                    else begin dmem_ack = 1'b0; dcnt--; end
                end else begin
                    dmem_ack = ($urandom_range(0, 3) == 0);
                    dcnt = dwait_cur;
                end
            end
        end
    end

    // Monitor: pops the expected record on each fetch and follows it to completion
    exp_t me;
    int   cyc = 0, nwe = 0, ndm = 0;
    initial begin
        forever begin
            @(negedge clk);
            if (!sb_hold && rst_n) begin
                if (mon_active && !mon_done) begin
                    cyc++;
                    if (cyc == 1 && me.chk_dec) begin
                        chk("alu_op", 64'(alu_op), 64'(me.alu_op));
                        chk("alu_src_imm", 64'(alu_src_imm), 64'(me.src_imm));
                        chk("alu_a_zero", 64'(alu_a_zero), 64'(me.a_zero));
                        chk("rs1", 64'(rs1), 64'(me.ins[19:15]));
                        chk("rs2", 64'(rs2), 64'(me.ins[24:20]));
                        chk("rd", 64'(rd), 64'(me.rd));
                        if (me.chk_imm) chk("imm", 64'(imm), 64'(me.imm));
                    end
                    if (rf_we) begin
                        nwe++;
                        chk("wb_rd", 64'(rd), 64'(me.rd));
                        chk("wb_sel", 64'(wb_sel), 64'(me.wb_sel));
                    end
                    if (dmem_req) begin
                        ndm++;
                        chk("dmem_we", 64'(dmem_we), 64'(me.dwe));
                    end
                    if (imem_req || halted) begin
                        chk("latency", 64'(cyc), 64'(me.lat));
                        chk("rf_we_cycles", 64'(nwe), 64'(me.nwe));
                        chk("dmem_cycles", 64'(ndm), 64'(me.ndm));
                        chk("halted", 64'(halted), 64'(me.trap));
                        mon_done = 1'b1;
                    end
                end
                if (imem_req && imem_ack) begin
                    if (exp_q.size() == 0) begin
                        fail("unexpected_fetch");
                    end else begin
                        me = exp_q.pop_front();
                        chk("fetch_pc", 64'(imem_addr), 64'(me.pc));
                        mon_active = 1'b1; mon_done = 1'b0;
                        cyc = 0; nwe = 0; ndm = 0;
                    end
                end
            end
        end
    end

    // Reset sequence; entered and left just after a posedge
    task automatic do_reset();
        sb_hold = 1'b1;
        issue_q.delete();
        rand_left = 0;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 64'(pc), 64'(PC_RESET));
        chk("rst_imem_req", 64'(imem_req), 64'd0);
        chk("rst_dmem_req", 64'(dmem_req), 64'd0);
        chk("rst_dmem_we", 64'(dmem_we), 64'd0);
        chk("rst_rf_we", 64'(rf_we), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
`ifdef RV_PERF_COUNTERS_EN
        chk("rst_cycle_cnt", cycle_cnt, 64'd0);
        chk("rst_instret_cnt", instret_cnt, 64'd0);
`endif
        @(posedge clk); #2;
        rst_n = 1'b1;
        exp_q.delete();
        model_pc = PC_RESET;
        mon_active = 1'b0;
        mon_done = 1'b1;
        sb_hold = 1'b0;
    endtask

    task automatic wait_idle(int budget);
        int n;
        n = 0;
        while (!(issue_q.size() == 0 && rand_left == 0 && !cur_loaded &&
                 exp_q.size() == 0 && mon_done) && n < budget) begin
            @(posedge clk); #2;
            n++;
        end
        if (n >= budget) fail("idle_timeout");
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        #2;
        do_reset();

        // ADDI, LW with delayed ack, BEQ/BNE both ways, ADD to x0, SW, LUI
        push_ins(32'hFFB0_0093, 1'b0, 0, 0);
        push_ins(32'h0080_2103, 1'b0, 0, 3);
        push_ins(32'h0010_0193, 1'b0, 1, 0);
        push_ins(32'h0010_0193, 1'b0, 0, 0);
        push_ins(32'hFE00_0CE3, 1'b1, 0, 0);
        push_ins(32'h0010_0193, 1'b0, 0, 0);
        push_ins(32'h0010_0193, 1'b0, 0, 0);
        push_ins(32'hFE00_0CE3, 1'b0, 0, 0);
        push_ins(32'hFE00_1CE3, 1'b1, 0, 0);
        push_ins(32'hFE00_1CE3, 1'b0, 2, 0);
        push_ins(32'h0020_8033, 1'b0, 0, 0);
        push_ins(32'h0020_2223, 1'b0, 0, 2);
        push_ins(32'h1234_52B7, 1'b0, 0, 0);
        wait_idle(500);

        // PC wraps: branch back from 0 then step forward through 0xFFFF_FFFC
        do_reset();
        push_ins(32'hFE00_0CE3, 1'b1, 0, 0);
        push_ins(32'h0010_0193, 1'b0, 0, 0);
        push_ins(32'h0010_0193, 1'b0, 0, 0);
        push_ins(32'h0010_0193, 1'b0, 0, 0);
        wait_idle(200);

        rand_left = 250;
        wait_idle(10000);

        // Illegal opcode traps and stays trapped
        push_ins(32'hFFFF_FFFF, 1'b0, 0, 0);
        wait_idle(100);
        repeat (8) begin
            @(negedge clk);
            chk("trap_halted", 64'(halted), 64'd1);
            chk("trap_imem_req", 64'(imem_req), 64'd0);
            chk("trap_pc", 64'(pc), 64'(model_pc));
        end
        @(posedge clk); #2;
        do_reset();
        @(negedge clk);
        chk("resume_imem_req", 64'(imem_req), 64'd1);
        chk("resume_addr", 64'(imem_addr), 64'(PC_RESET));
        @(posedge clk); #2;

        // Reset while a data access is outstanding
        push_ins(32'h0080_2103, 1'b0, 0, 40);
        n = 0;
        while (!dmem_req && n < 30) begin
            @(posedge clk); #2;
            n++;
        end
        if (!dmem_req) fail("mem_wait_timeout");
        do_reset();
        push_ins(32'hFFB0_0093, 1'b0, 0, 0);
        wait_idle(100);

        $display("Result: errors=%0d of %0d checks", errors, nchecks);
        $finish;
    end

endmodule
